mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative RV32M multiply/divide unit for the execute stage of the RISC-V core. It is fed by the same register-file operand buses (A, B) and funct3 field as the ALU. Its registered result goes to the writeback select alongside the ALU Result. The hazard logic holds the pipeline while busy is high.

## Interface
Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only when the unit is in IDLE or DONE.
- A  input  XLEN  rs1 operand (multiplicand / dividend).
- B  input  XLEN  rs2 operand (multiplier / divisor).
- funct3  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- busy  output  1  high from the cycle after start is accepted through the FIX cycle.
- done  output  1  one-cycle pulse; Result is valid in that cycle.
- Result  output  XLEN  registered result; holds its value until the next FIX.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE + start on an edge:
  - latch funct3;
  - latch the operand magnitudes (abs value for signed operands: MULH both, MULHSU A only, DIV/REM both);
  - latch the result sign: product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA;
  - clear the iteration counter and the accumulators; go to RUN.
- IDLE/DONE without start: DONE→IDLE, IDLE stays.
- RUN: one iteration per edge, counter increments. Go to FIX after iteration XLEN-1.
  - Multiply: shift-add over a 2·XLEN-bit product register.
  - Divide: restoring step. Shift the remainder left, bring in the next dividend bit, subtract the divisor, keep the difference if it is non-negative, set the quotient bit.
- FIX: apply two's-complement negation where the latched sign requires it. Select the output:
  - MUL: low word;
  - MULH/MULHSU/MULHU: high word;
  - DIV/DIVU: quotient;
  - REM/REMU: remainder.
  - Register into Result; go to DONE.
- Special cases, forced in FIX (RISC-V spec values):
  - divide by zero: DIV/DIVU Result = 0xFFFFFFFF; REM/REMU Result = A.
  - signed overflow, A=0x80000000 and B=0xFFFFFFFF: DIV Result = 0x80000000, REM Result = 0.
- start while in RUN/FIX is ignored; there is no queueing.
- Operands A/B may change after acceptance; only the latched values are used.

## Timing
- Reset values: state IDLE, busy 0, done 0, Result 0, counter 0.
- Reset mid-operation aborts immediately. No done pulse occurs, and Result returns to 0.
- Latency (normal path): start accepted at edge k; RUN edges k+1..k+XLEN; FIX edge k+XLEN+1; done high in the cycle after edge k+XLEN+1. For XLEN=32 this is 34 cycles from the accepting edge to done.
- busy is high for XLEN+1 cycles (RUN + FIX). busy and done are never high together.
- Back-to-back: start in the done cycle is accepted. The next RUN begins with no idle bubble.
- Throughput: one operation per XLEN+2 cycles.

## Configuration
- MULDIV_EARLY_OUT_EN defined: divide-by-zero and signed-overflow cases are detected when start is accepted. The unit then goes straight to FIX, skipping RUN. done follows two cycles after the accepting edge, and busy is high for one cycle. All other operations keep the normal latency.
- Not defined: every operation takes the fixed XLEN+2 latency. Special-case values are still forced in FIX.

## Structure
- Shared package muldiv_pkg:
  - funct3 encoding constants (F3_MUL … F3_REMU);
  - state enum (IDLE, RUN, FIX, DONE);
  - XLEN default and counter width $clog2(XLEN).
- One combinational sub-module, div_step. Inputs are the partial remainder, the next dividend bit and the divisor. Outputs are the next remainder and the quotient bit. It is instantiated once in RUN.
- The multiply step and sign fix stay inline.

## Test plan
- MUL A=7, B=-3 (0xFFFFFFFD): start → done after 34 cycles, Result 0xFFFFFFEB; MULH same operands → 0xFFFFFFFF; MULHU → 0x00000006.
- DIV A=-20, B=3 → Result 0xFFFFFFFA (-6); REM same operands → 0xFFFFFFFE (-2); DIVU A=100, B=7 → 14; REMU → 2.
- DIVU A=0x1234, B=0 → 0xFFFFFFFF; REMU → 0x1234. Check done after 34 cycles without the macro and 2 cycles with it.
- DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000; REM → 0.
- Back-to-back and ignore: MULHSU A=-1, B=2 → 0xFFFFFFFF.
  - Assert start again in the done cycle with MUL 5×6; Result 30 arrives 34 cycles later with no bubble.
  - A start pulse mid-RUN changes nothing.
- Reset abort: assert rst at RUN iteration 10. Next cycle busy=0, done=0, Result=0, state IDLE; no done pulse follows.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state type, default width and counter width.
package muldiv_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = $clog2(XLEN_DEF);

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/mul_div_unit_div_step.sv
// One restoring-division step: shift the partial remainder left, bring in
// the next dividend bit, subtract the divisor and keep the difference when
// it is non-negative.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted;

  // Trial subtraction; a kept difference is always below the divisor, so it fits in XLEN bits.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? XLEN'(shifted - {1'b0, divisor}) : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Optional build macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed
// overflow skip RUN and go straight to FIX.
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [2:0]      funct3,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state;
  logic [2:0]          f3;
  logic [XLEN-1:0]     mag_a, mag_b, a_raw, rem, quo;
  logic [2*XLEN-1:0]   prod;
  logic                neg, dz, ovf;
  logic [CNT_W-1:0]    cnt;

  logic                sa, sb, start_dz, start_ovf, early_out;
  logic [XLEN-1:0]     in_mag_a, in_mag_b;
  logic [XLEN:0]       add_sum;
  logic [2*XLEN-1:0]   prod_nxt, mul_full;
  logic [XLEN-1:0]     rem_nxt, quo_s, rem_s, fix_res;
  logic                q_bit;

  // Decode operand signs, magnitudes and special cases at the request.
  always_comb begin
    sa        = A[XLEN-1] & (funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
    sb        = B[XLEN-1] & (funct3 inside {F3_MULH, F3_DIV, F3_REM});
    in_mag_a  = sa ? -A : A;
    in_mag_b  = sb ? -B : B;
    start_dz  = (B == '0);
    start_ovf = (funct3 inside {F3_DIV, F3_REM}) && (A == MIN_NEG) && (B == '1);
`ifdef MULDIV_EARLY_OUT_EN
    early_out = funct3[2] & (start_dz | start_ovf);
`else
    early_out = 1'b0;
`endif
  end

  // Shift-add multiply step: multiplier sits in the low half and shifts out.
  always_comb begin
    add_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, (prod[0] ? mag_a : '0)};
    prod_nxt = {add_sum, prod[XLEN-1:1]};
  end

  // quo starts holding the dividend; its MSB feeds the step and quotient bits fill from the right.
  div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in       (rem),
    .dividend_bit (quo[XLEN-1]),
    .divisor      (mag_b),
    .rem_out      (rem_nxt),
    .q_bit        (q_bit)
  );

  // Sign fix, output select and RISC-V special-case override.
  always_comb begin
    mul_full = neg ? -prod : prod;
    quo_s    = neg ? -quo : quo;
    rem_s    = neg ? -rem : rem;
    unique case (f3)
      F3_MUL:                       fix_res = mul_full[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = mul_full[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_res = dz ? '1 : (ovf ? MIN_NEG : quo_s);
      default:                      fix_res = dz ? a_raw : (ovf ? '0 : rem_s);
    endcase
  end

  // Control FSM with registered busy/done/Result and the iteration datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      Result <= '0;
      cnt    <= '0;
      f3     <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      a_raw  <= '0;
      rem    <= '0;
      quo    <= '0;
      prod   <= '0;
      neg    <= 1'b0;
      dz     <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            f3    <= funct3;
            mag_a <= in_mag_a;
            mag_b <= in_mag_b;
            a_raw <= A;
            neg   <= (funct3 == F3_REM) ? sa : (sa ^ sb);
            dz    <= start_dz;
            ovf   <= start_ovf;
            cnt   <= '0;
            rem   <= '0;
            quo   <= in_mag_a;
            prod  <= {{XLEN{1'b0}}, in_mag_b};
            busy  <= 1'b1;
            state <= early_out ? FIX : RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (f3[2]) begin
            rem <= rem_nxt;
            quo <= {quo[XLEN-2:0], q_bit};
          end else begin
            prod <= prod_nxt;
          end
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          Result <= fix_res;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus randomized
// operations against an arithmetic reference model.
module tb_mul_div_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] A, B;
  logic [2:0]  funct3;
  logic        busy, done;
  logic [31:0] Result;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .funct3 (funct3),
    .busy   (busy),
    .done   (done),
    .Result (Result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  // RISC-V M-extension semantics computed with plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    logic [63:0] ua64 = {32'b0, a};
    logic [63:0] ub64 = {32'b0, b};
    logic        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = ua64 * ub64; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit special = f[2] && ((b == 0) ||
                  ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`ifdef MULDIV_EARLY_OUT_EN
    return special ? 2 : 34;
`else
    return (special && 1'b0) ? 2 : 34;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // busy and done must never overlap.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert (!(busy && done)) else begin
        errors++;
        $error("FAIL busy_done_overlap: busy %b done %b", busy, done);
      end
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle (start low).
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit glitch, input string tag);
    int lat;
    int bcnt;
    int elat = exp_latency(f, a, b);
    start = 1'b1; funct3 = f; A = a; B = b;
    @(posedge clk);
    lat = 1; bcnt = 0;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; funct3 = 3'($urandom);
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      start = glitch && (lat == 10);
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
    end
    check({tag, "_result"}, Result, exp);
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(elat - 1));
  endtask

  vec_t dir[$];

  initial begin
    int dcount;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; funct3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", Result, 32'd0);
    check("reset_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    dir.push_back('{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB});
    dir.push_back('{3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF});
    dir.push_back('{3'd3, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006});
    dir.push_back('{3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA});
    dir.push_back('{3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE});
    dir.push_back('{3'd5, 32'd100, 32'd7, 32'd14});
    dir.push_back('{3'd7, 32'd100, 32'd7, 32'd2});
    dir.push_back('{3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF});
    dir.push_back('{3'd7, 32'h1234, 32'd0, 32'h1234});
    dir.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    dir.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0});
    dir.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF});
    foreach (dir[i]) begin
      run_op(dir[i].f, dir[i].a, dir[i].b, dir[i].exp, 1'b0, $sformatf("dir%0d", i));
      check($sformatf("dir%0d_model", i), model(dir[i].f, dir[i].a, dir[i].b), dir[i].exp);
      if (i != dir.size() - 1) @(negedge clk);
    end
    // Back-to-back from the MULHSU done cycle, with a stray start mid-RUN.
    run_op(3'd0, 32'd5, 32'd6, 32'd30, 1'b1, "b2b_mul");
    @(negedge clk);

    // Reset abort during RUN.
    start = 1'b1; funct3 = 3'd4; A = 32'd1000; B = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", Result, 32'd0);
    check("abort_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  f = 3'($urandom_range(0, 7));
      logic [31:0] a = $urandom;
      logic [31:0] b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($signed($urandom_range(0, 200)) - 100); b = 32'($signed($urandom_range(0, 20)) - 10); end
        default: ;
      endcase
      run_op(f, a, b, model(f, a, b), 1'b0, $sformatf("rnd%0d_f%0d", n, f));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
